// File: rtl/sram_controller_pkg.sv
// -----------------------------------------------------------------------------
// sram_controller_pkg
//
// Shared types and constants for the asynchronous SRAM controller.
//
// Contents:
//   Word_t        32-bit CPU / SRAM data word
//   Mask_t        4-bit byte-enable mask (one bit per byte lane)
//   Bit_t         single control bit
//   Ram_addr_t    SRAM word address, byte address bits [SRAM_ADDR_MSB:SRAM_ADDR_LSB]
//   HIGH_WORD     value of a released (undriven) data bus
//   Sram_state_t  controller sequencing states
//
// Configuration macro: SRAM_READ_WAIT_EN adds the READ_WAIT state, which
// stretches every read by one cycle for slower devices.
// -----------------------------------------------------------------------------
package sram_controller_pkg;

    typedef logic [31:0] Word_t;
    typedef logic [3:0]  Mask_t;
    typedef logic        Bit_t;

    // Byte-address bits that select a 32-bit SRAM word.
    localparam int SRAM_ADDR_LSB = 2;
    localparam int SRAM_ADDR_MSB = 21;

    typedef logic [SRAM_ADDR_MSB-SRAM_ADDR_LSB:0] Ram_addr_t;

    // Released data bus: every bit high impedance.
    localparam Word_t HIGH_WORD = 'z;

    // Inactive level of the active-low byte enables.
    localparam Mask_t BE_N_OFF = '1;

    typedef enum logic [2:0] {
        IDLE,
        READ,
`ifdef SRAM_READ_WAIT_EN
        READ_WAIT,
`endif
        WSETUP,
        WPULSE,
        WHOLD,
        DONE
    } Sram_state_t;

endpackage : sram_controller_pkg

// File: rtl/sram_controller.sv
// -----------------------------------------------------------------------------
// sram_controller
//
// Bridges a single-outstanding CPU request bus to an asynchronous SRAM.
// The controller sequences chip-select, output-enable and write-enable,
// owns the tri-state data bus, and returns a one-cycle acknowledge with the
// captured read data.
//
// Every pin output, ack, rdata and the bus drive enable come straight from
// flops, so the SRAM sees glitch-free strobes.
//
// Ports:
//   clk       system clock (single domain)
//   rst_n     asynchronous active-low reset
//   req       request valid, held by the requester until ack
//   we        1 = write, 0 = read (sampled with req)
//   addr      byte address; only bits [21:2] reach the SRAM
//   wdata     write data
//   be        byte enables, active-high
//   rdata     read data, valid while ack is high on a read, held otherwise
//   ack       one-cycle completion pulse
//   busy      high whenever a transaction is in progress
//   ram_data  bidirectional SRAM data bus
//   ram_addr  SRAM word address
//   ram_be_n  SRAM byte enables, active-low
//   ram_ce_n  SRAM chip enable, active-low
//   ram_oe_n  SRAM output enable, active-low
//   ram_we_n  SRAM write enable, active-low
//
// Configuration macro: SRAM_READ_WAIT_EN
//   undefined  read  = IDLE -> READ -> DONE              (latency 2)
//   defined    read  = IDLE -> READ -> READ_WAIT -> DONE  (latency 3)
//   write is IDLE -> WSETUP -> WPULSE -> WHOLD -> DONE in both builds.
// -----------------------------------------------------------------------------
module sram_controller
    import sram_controller_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,

    input  logic      req,
    input  logic      we,
    input  Word_t     addr,
    input  Word_t     wdata,
    input  Mask_t     be,
    output Word_t     rdata,
    output Bit_t      ack,
    output Bit_t      busy,

    inout  wire [31:0] ram_data,
    output Ram_addr_t ram_addr,
    output Mask_t     ram_be_n,
    output Bit_t      ram_ce_n,
    output Bit_t      ram_oe_n,
    output Bit_t      ram_we_n
);

    Sram_state_t state;
    Word_t       wdata_q;   // write data latched at accept
    Bit_t        drive_en;  // registered tri-state enable for ram_data

    // Address bits outside the SRAM window are intentionally ignored.
    Bit_t unused_addr_bits;
    assign unused_addr_bits = ^{addr[31:SRAM_ADDR_MSB+1], addr[SRAM_ADDR_LSB-1:0]};

    assign busy = (state != IDLE);

    // The drive enable is only ever set on the write path, where oe_n is
    // held high, so the controller and the SRAM never fight for the bus.
    assign ram_data = drive_en ? wdata_q : HIGH_WORD;

    // NOTE: all state and pin registers use non-blocking assignments so every
    // flop samples pre-edge values; blocking here would create ordering races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ram_addr <= '0;
            ram_be_n <= BE_N_OFF;
            ram_ce_n <= 1'b1;
            ram_oe_n <= 1'b1;
            ram_we_n <= 1'b1;
            drive_en <= 1'b0;
            wdata_q  <= '0;
            rdata    <= '0;
            ack      <= 1'b0;
        end else begin
            // ack is a single-cycle pulse; only the edge entering DONE raises it.
            ack <= 1'b0;

            // NOTE: the default arm keeps the case complete, so an illegal
            // encoding recovers to IDLE instead of sticking.
            unique case (state)
                IDLE: begin
                    if (req) begin
                        ram_addr <= addr[SRAM_ADDR_MSB:SRAM_ADDR_LSB];
                        ram_ce_n <= 1'b0;
                        if (we) begin
                            // Data and lane mask are frozen here, so later
                            // changes on the request bus cannot disturb the cycle.
                            wdata_q  <= wdata;
                            ram_be_n <= ~be;
                            drive_en <= 1'b1;
                            state    <= WSETUP;
                        end else begin
                            // Reads always fetch the full word.
                            ram_oe_n <= 1'b0;
                            ram_be_n <= '0;
                            state    <= READ;
                        end
                    end
                end

`ifdef SRAM_READ_WAIT_EN
                READ: begin
                    // Pins unchanged: the extra cycle only lengthens access time.
                    state <= READ_WAIT;
                end

                READ_WAIT: begin
                    rdata    <= ram_data;
                    ram_ce_n <= 1'b1;
                    ram_oe_n <= 1'b1;
                    ram_be_n <= BE_N_OFF;
                    ack      <= 1'b1;
                    state    <= DONE;
                end
`else
                READ: begin
                    rdata    <= ram_data;
                    ram_ce_n <= 1'b1;
                    ram_oe_n <= 1'b1;
                    ram_be_n <= BE_N_OFF;
                    ack      <= 1'b1;
                    state    <= DONE;
                end
`endif

                WSETUP: begin
                    // Address and data have had a full cycle to settle.
                    ram_we_n <= 1'b0;
                    state    <= WPULSE;
                end

                WPULSE: begin
                    // The rising we_n edge is where the device latches the data.
                    ram_we_n <= 1'b1;
                    state    <= WHOLD;
                end

                WHOLD: begin
                    // Data stayed driven through this cycle to meet hold time.
                    ram_ce_n <= 1'b1;
                    ram_be_n <= BE_N_OFF;
                    drive_en <= 1'b0;
                    ack      <= 1'b1;
                    state    <= DONE;
                end

                DONE: begin
                    // Unconditional: a held req is sampled only once back in IDLE.
                    state <= IDLE;
                end

                default: begin
                    ram_ce_n <= 1'b1;
                    ram_oe_n <= 1'b1;
                    ram_we_n <= 1'b1;
                    ram_be_n <= BE_N_OFF;
                    drive_en <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule : sram_controller

// File: tb/tb_sram_controller.sv
// -----------------------------------------------------------------------------
// tb_sram_controller
//
// Self-checking bench for sram_controller. A behavioural SRAM device sits on
// the pins. Expected responses are queued when a request is issued, and a
// monitor checks them when ack appears. Reads are checked against a
// word-addressed reference memory that applies byte-enable merges.
// Build with +define+SRAM_READ_WAIT_EN to check the stretched-read variant.
// -----------------------------------------------------------------------------
module tb_sram_controller;
    import sram_controller_pkg::*;

`ifdef SRAM_READ_WAIT_EN
    localparam int RD_LAT = 3;
`else
    localparam int RD_LAT = 2;
`endif
    localparam int WR_LAT = 4;

    logic      clk = 1'b0;
    logic      rst_n;
    logic      req;
    logic      we;
    Word_t     addr;
    Word_t     wdata;
    Mask_t     be;
    Word_t     rdata;
    Bit_t      ack;
    Bit_t      busy;
    wire [31:0] ram_data;
    Ram_addr_t ram_addr;
    Mask_t     ram_be_n;
    Bit_t      ram_ce_n;
    Bit_t      ram_oe_n;
    Bit_t      ram_we_n;

    sram_controller dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .we       (we),
        .addr     (addr),
        .wdata    (wdata),
        .be       (be),
        .rdata    (rdata),
        .ack      (ack),
        .busy     (busy),
        .ram_data (ram_data),
        .ram_addr (ram_addr),
        .ram_be_n (ram_be_n),
        .ram_ce_n (ram_ce_n),
        .ram_oe_n (ram_oe_n),
        .ram_we_n (ram_we_n)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- SRAM device model ----------------
    // Stimulus only uses word addresses with bits [18:10] zero, so bit 19 plus
    // bits [9:0] index the device array without aliasing.
    logic [31:0] dev_mem [2048];

    assign ram_data = (!ram_ce_n && !ram_oe_n) ? dev_mem[{ram_addr[19], ram_addr[9:0]}] : 'z;

    // The device latches on the edge that ends the we_n pulse.
    always @(posedge clk) begin
        if (!ram_ce_n && !ram_we_n) begin
            for (int i = 0; i < 4; i++) begin
                if (!ram_be_n[i])
                    dev_mem[{ram_addr[19], ram_addr[9:0]}][i*8 +: 8] <= ram_data[i*8 +: 8];
            end
        end
    end

    // ---------------- reference model & scoreboard ----------------
    logic [31:0] ref_mem [logic [19:0]];

    function automatic logic [31:0] ref_rd(input logic [19:0] w);
        return ref_mem.exists(w) ? ref_mem[w] : 32'h0;
    endfunction

    typedef struct {
        bit          is_read;
        logic [31:0] exp_data;
        int          exp_cyc;
        logic [19:0] word;
        logic [3:0]  be_n;
        logic [31:0] wdata;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int n_cmp = 0;
    int n_bad = 0;
    int excl_viol = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual 0x%08h, required 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!ram_we_n && !ram_oe_n) excl_viol++;
        if (rst_n) begin
            if (sb.size() > 0 && !ram_we_n) begin
                check("wr_addr", 32'(ram_addr), 32'(sb[0].word));
                check("wr_be_n", 32'(ram_be_n), 32'(sb[0].be_n));
                check("wr_data", ram_data, sb[0].wdata);
            end
            if (sb.size() > 0 && !ram_oe_n) begin
                check("rd_addr", 32'(ram_addr), 32'(sb[0].word));
                check("rd_be_n", 32'(ram_be_n), 32'h0);
            end
            if (ack) begin
                if (sb.size() == 0) begin
                    check("unexpected_ack", 32'(ack), 32'h0);
                end else begin
                    mon_e = sb.pop_front();
                    check("ack_cycle", cyc, mon_e.exp_cyc);
                    if (mon_e.is_read) check("rdata", rdata, mon_e.exp_data);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    // Called on a negedge. b2b = called in the ack cycle of the previous
    // request with req kept high, so acceptance is two edges away.
    task automatic issue(input bit w, input Word_t a, input Word_t d, input Mask_t b, input bit b2b);
        exp_t        e;
        bit          got;
        logic [31:0] merged;
        req   = 1'b1;
        we    = w;
        addr  = a;
        wdata = d;
        be    = b;
        e.word    = a[21:2];
        e.is_read = !w;
        e.be_n    = ~b;
        e.wdata   = d;
        e.exp_cyc = (b2b ? cyc + 2 : cyc + 1) + (w ? WR_LAT : RD_LAT) - 1;
        if (w) begin
            merged = ref_rd(e.word);
            for (int i = 0; i < 4; i++)
                if (b[i]) merged[i*8 +: 8] = d[i*8 +: 8];
            ref_mem[e.word] = merged;
            e.exp_data = 32'h0;
        end else begin
            e.exp_data = ref_rd(e.word);
        end
        sb.push_back(e);
        got = 1'b0;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            if (ack) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("ack_timeout", 32'h0, 32'h1);
    endtask

    task automatic idle();
        req = 1'b0;
        @(negedge clk);
    endtask

    function automatic Word_t rand_addr();
        logic [19:0] w;
        Word_t       a;
        w = {1'($urandom), 9'b0, 10'($urandom_range(0, 15))};
        a = $urandom;
        a[21:2] = w;
        return a;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit b2b;
        for (int i = 0; i < 2048; i++) dev_mem[i] = 32'h0;
        rst_n = 1'b1;
        req   = 1'b0;
        we    = 1'b0;
        addr  = '0;
        wdata = '0;
        be    = '0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_ce_n", 32'(ram_ce_n), 32'h1);
        check("rst_oe_n", 32'(ram_oe_n), 32'h1);
        check("rst_we_n", 32'(ram_we_n), 32'h1);
        check("rst_be_n", 32'(ram_be_n), 32'hF);
        check("rst_ack",  32'(ack),      32'h0);
        check("rst_rdata", rdata,        32'h0);
        check("rst_busy", 32'(busy),     32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Write then read
        issue(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0); idle();
        issue(1'b0, 32'h0000_0010, 32'h0, 4'h0, 1'b0);
        check("rd_0x10", rdata, 32'hDEAD_BEEF);
        idle();

        // Partial write, then an all-lanes-off write that must change nothing
        issue(1'b1, 32'h0000_0020, 32'h1122_3344, 4'hF, 1'b0); idle();
        issue(1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'b0101, 1'b0); idle();
        issue(1'b0, 32'h0000_0020, 32'h0, 4'h0, 1'b0);
        check("rd_partial", rdata, 32'h11BB_33DD);
        idle();
        issue(1'b1, 32'h0000_0020, 32'h5555_AAAA, 4'h0, 1'b0); idle();
        issue(1'b0, 32'h0000_0020, 32'h0, 4'h0, 1'b0);
        check("rd_be0", rdata, 32'h11BB_33DD);
        idle();

        // Request bus churn during a write is ignored
        begin
            exp_t e;
            bit   got;
            req = 1'b1; we = 1'b1; addr = 32'h0000_0040; wdata = 32'hCAFE_F00D; be = 4'hF;
            e.word = 20'h10; e.is_read = 1'b0; e.be_n = 4'h0; e.wdata = 32'hCAFE_F00D;
            e.exp_data = 32'h0; e.exp_cyc = cyc + 1 + WR_LAT - 1;
            ref_mem[20'h10] = 32'hCAFE_F00D;
            sb.push_back(e);
            got = 1'b0;
            for (int k = 0; k < 24; k++) begin
                @(negedge clk);
                if (k == 0) check("busy_mid", 32'(busy), 32'h1);
                if (ack) begin
                    got = 1'b1;
                    break;
                end
                req = 1'($urandom); we = 1'($urandom); addr = $urandom;
                wdata = $urandom; be = 4'($urandom);
            end
            if (!got) check("ack_timeout", 32'h0, 32'h1);
            idle();
            repeat (2) @(negedge clk);
            issue(1'b0, 32'h0000_0040, 32'h0, 4'h0, 1'b0);
            check("rd_churn", rdata, 32'hCAFE_F00D);
            idle();
        end

        // Reset during the write pulse
        req = 1'b1; we = 1'b1; addr = 32'h0000_0010; wdata = 32'h0BAD_F00D; be = 4'hF;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        check("pulse_we_n", 32'(ram_we_n), 32'h0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ce_n", 32'(ram_ce_n), 32'h1);
        check("mid_rst_we_n", 32'(ram_we_n), 32'h1);
        check("mid_rst_oe_n", 32'(ram_oe_n), 32'h1);
        check("mid_rst_be_n", 32'(ram_be_n), 32'hF);
        check("mid_rst_addr", 32'(ram_addr), 32'h0);
        check("mid_rst_rdata", rdata, 32'h0);
        check("mid_rst_ack", 32'(ack), 32'h0);
        check("mid_rst_busy", 32'(busy), 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        issue(1'b0, 32'h0000_0010, 32'h0, 4'h0, 1'b0);
        check("rd_after_rst", rdata, 32'hDEAD_BEEF);
        idle();

        // Back-to-back reads with req held high
        issue(1'b0, 32'h0000_0010, 32'h0, 4'h0, 1'b0);
        issue(1'b0, 32'h0000_0020, 32'h0, 4'h0, 1'b1);
        issue(1'b0, 32'h0000_0040, 32'h0, 4'h0, 1'b1);
        issue(1'b0, 32'h0000_0010, 32'h0, 4'h0, 1'b1);
        idle();

        // Randomized mix
        b2b = 1'b0;
        for (int n = 0; n < 120; n++) begin
            issue(1'($urandom_range(0, 1)), rand_addr(), $urandom, 4'($urandom), b2b);
            if ($urandom_range(0, 1) == 1) begin
                idle();
                b2b = 1'b0;
            end else begin
                b2b = 1'b1;
            end
        end
        idle();
        repeat (4) @(negedge clk);

        check("sb_drained", 32'(sb.size()), 32'h0);
        check("strobe_excl", 32'(excl_viol), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_sram_controller

// File: doc/sram_controller.md
# sram_controller

- Bridges the CPU-side single-outstanding memory request bus to the asynchronous external SRAM pins (`ram_data`/`ram_addr`/`ram_be_n`/`ram_ce_n`/`ram_oe_n`/`ram_we_n`).
- Sits directly upstream of the SRAM device or its bench model.
- Sequences chip-select, output-enable and write-enable, and owns the tri-state data bus.
- Returns one-cycle acknowledges with captured read data.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  system clock. One clock domain.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req`  in  1  request valid; held by the requester until `ack`.
- `we`  in  1  1 = write, 0 = read; sampled with `req`.
- `addr`  in  Word_t  byte address; bits [21:2] are used.
- `wdata`  in  Word_t  write data.
- `be`  in  Mask_t  byte enables, active-high.
- `rdata`  out  Word_t  read data; valid while `ack`=1 on a read; holds its value otherwise.
- `ack`  out  Bit_t  one-cycle completion pulse.
- `busy`  out  Bit_t  1 whenever the state is not IDLE.
- `ram_data`  inout  Word_t  SRAM data bus.
- `ram_addr`  out  Ram_addr_t  SRAM word address.
- `ram_be_n`  out  Mask_t  SRAM byte enables, active-low.
- `ram_ce_n`, `ram_oe_n`, `ram_we_n`  out  Bit_t  SRAM strobes, active-low.

## Operation
All pin outputs, `ack` and `rdata` are registered. Tri-state enable is registered.

States: IDLE, READ, [READ_WAIT], WSETUP, WPULSE, WHOLD, DONE.
- **IDLE**
  - All strobes high, `ram_data` = `HIGH_WORD`.
  - `req`=1 latches `addr[21:2]` into `ram_addr`.
  - `we`=0 → READ.
  - `we`=1 → WSETUP; latches `wdata` and `~be`.
- **READ**
  - `ce_n`=0, `oe_n`=0, `we_n`=1, `be_n`=0000.
  - → DONE, capturing `ram_data` into `rdata` on that edge.
- **WSETUP**
  - `ce_n`=0, `oe_n`=1, `we_n`=1.
  - `ram_data` is driven with the latched write data.
  - → WPULSE.
- **WPULSE**: `we_n`=0; data and address stable. → WHOLD.
- **WHOLD**: `we_n`=1; `ce_n`=0; data still driven. → DONE.
- **DONE**
  - All strobes high, bus released.
  - `ack`=1 for exactly this cycle.
  - → IDLE.

Rules:
- `req` is ignored outside IDLE.
- `req`, `we`, `addr`, `wdata` and `be` changing mid-transaction have no effect.
- `be`=0000 on a write still runs the full sequence; no byte changes; `ack` still pulses.
- `we_n` and `oe_n` are never low simultaneously.
- `ram_data` is never driven while `oe_n`=0.

Reset (`rst_n`=0, any state, mid-transaction included), asynchronously:
- state=IDLE.
- `ram_ce_n`=`ram_oe_n`=`ram_we_n`=1, `ram_be_n`=1111.
- `ram_addr`=0, `ram_data` released (`HIGH_WORD`).
- `rdata`=0, `ack`=0, `busy`=0.
- No `ack` is produced for the aborted request.

## Timing
Edge E0 is the edge on which IDLE samples `req`=1.

- **Read**
  - Pins active after E0.
  - `rdata` captured at E1.
  - `ack` high E1–E2.
  - Back in IDLE after E2.
  - Latency 2 cycles; minimum issue interval 3 cycles.
- **Write**
  - Setup E0–E1, pulse E1–E2; the device samples on E2.
  - Hold E2–E3.
  - `ack` high E3–E4.
  - Latency 4 cycles; minimum interval 5 cycles.
- **Back-to-back**
  - A `req` held through DONE is accepted on the edge that leaves DONE? No: DONE → IDLE unconditionally.
  - A new request is sampled at the first IDLE edge, one cycle after `ack` falls.
  - The requester drops or updates `req` in the `ack` cycle.

## Configuration
- Macro: `SRAM_READ_WAIT_EN`.
- **Defined**
  - READ → READ_WAIT → DONE.
  - READ_WAIT keeps READ's pin values.
  - `rdata` is captured at the READ_WAIT exit edge.
  - Read latency 3, interval 4.
- **Undefined**: READ_WAIT does not exist; behaviour as above.
- Write timing is identical in both builds.

## Structure
- `Sram_state_t` enum and `SRAM_ADDR_LSB`=2 / `SRAM_ADDR_MSB`=21 constants go in `peripheral_defines.svh`.
- `Word_t`, `Mask_t`, `Bit_t`, `Ram_addr_t` and `HIGH_WORD` are reused from the shared headers.
- Single module; no sub-module is natural.

## Test plan
Bench: the SRAM bench model on the pins.

1. **Reset values**: `rst_n`=0 → all strobes 1, `ram_be_n`=1111, `ram_data`=Z, `ack`=0, `rdata`=0.
2. **Write then read**
   - Write `addr`=0x0000_0010, `wdata`=0xDEAD_BEEF, `be`=1111 → `ram_addr`=4; `ack` 4 cycles after accept.
   - Then read `addr` 0x10 → `rdata`=0xDEAD_BEEF with `ack` 2 cycles after accept (3 with `SRAM_READ_WAIT_EN`).
3. **Partial write**
   - Write 0x1122_3344 with `be`=1111 to 0x20.
   - Then write 0xAABB_CCDD with `be`=0101 to 0x20.
   - Read → 0x11BB_33DD.
4. **Busy and strobe exclusion**: `req` toggled and `addr` changed during a write → ignored, single `ack`; `we_n` and `oe_n` never both 0.
5. **Reset mid-write**: `rst_n` asserted during WPULSE → strobes high immediately, no `ack`, next read of that address unchanged.
6. **Back-to-back reads**: `req` held high → `ack` every 3 cycles (4 with macro), data per address correct.
